// File: rtl/if_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls in, instruction-memory bus, IF/ID register out.
// master = the fetch stage, slave = the surrounding pipeline and instruction ROM.
interface if_stage_if #(
   parameter int unsigned IMEM_AW = 8
);
   logic               stall;
   logic               flush;
   logic               branch_taken;
   logic [31:0]        branch_target;
   logic               J;
   logic               JR;
   logic [31:0]        jr_target;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_rdata;
   logic [31:0]        PC;
   logic [31:0]        Instruction_id;
   logic [31:0]        PC4_id;
   logic               valid_id;

   modport master (
      input  stall, flush, branch_taken, branch_target, J, JR, jr_target, imem_rdata,
      output imem_addr, PC, Instruction_id, PC4_id, valid_id
   );

   modport slave (
      output stall, flush, branch_taken, branch_target, J, JR, jr_target, imem_rdata,
      input  imem_addr, PC, Instruction_id, PC4_id, valid_id
   );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, next-PC selection and the IF/ID pipeline register.
// RUN/HOLD/REDIRECT are implicit in the PC and valid_id; no separate state register exists.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned IMEM_AW  = 8
) (
   input logic        clk,
   input logic        rst,
   if_stage_if.master bus
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;

   logic [31:0] pc_plus4;
   logic [31:0] jump_target;
   logic        j_take;
   logic        jr_take;

   assign pc_plus4    = pc_q + 32'd4;
   assign jump_target = {pc4_q[31:28], instr_q[25:0], 2'b00};
   // A bubble decodes as nop, so J/JR from an invalid slot must never redirect.
   assign jr_take     = bus.JR & valid_q;
   assign j_take      = bus.J & valid_q & ~bus.JR;

   always_comb begin
      pc_d = pc_plus4;
      if (bus.branch_taken) begin
         pc_d = bus.branch_target & ~32'h3;
      end else if (bus.stall) begin
         pc_d = pc_q;
      end else if (jr_take) begin
         pc_d = bus.jr_target & ~32'h3;
      end else if (j_take) begin
         pc_d = jump_target;
      end
   end

   always_comb begin
      instr_d = bus.imem_rdata;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      if (bus.branch_taken || bus.flush) begin
         instr_d = 32'h0;
         pc4_d   = pc4_q;
         valid_d = 1'b0;
      end else if (bus.stall) begin
         instr_d = instr_q;
         pc4_d   = pc4_q;
         valid_d = valid_q;
      end else if (jr_take || j_take) begin
         // Squash the sequential fetch that followed the jump.
         instr_d = 32'h0;
         pc4_d   = pc4_q;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         instr_q <= 32'h0;
         pc4_q   <= 32'h0;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign bus.imem_addr      = pc_q[IMEM_AW+1:2];
   assign bus.PC             = pc_q;
   assign bus.Instruction_id = instr_q;
   assign bus.PC4_id         = pc4_q;
   assign bus.valid_id       = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios with literal expectations, then
// randomized control inputs checked every cycle against a behavioural fetch model.
module tb_if_stage;

   logic clk = 1'b0;
   logic rst;
   logic stall2;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [31:0] rom [256];

   if_stage_if #(.IMEM_AW(8)) bus1 ();
   if_stage_if #(.IMEM_AW(8)) bus2 ();

   if_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   if_stage #(.RESET_PC(32'hFFFF_FFFC), .IMEM_AW(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   assign bus1.imem_rdata    = rom[bus1.imem_addr];
   assign bus2.imem_rdata    = rom[bus2.imem_addr];
   assign bus2.stall         = stall2;
   assign bus2.flush         = 1'b0;
   assign bus2.branch_taken  = 1'b0;
   assign bus2.branch_target = 32'h0;
   assign bus2.J             = 1'b0;
   assign bus2.JR            = 1'b0;
   assign bus2.jr_target     = 32'h0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Behavioural model: architectural PC plus IF/ID contents, stepped once per edge.
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid;
   bit          m_live = 0;

   always @(posedge clk) begin
      logic [31:0] seq, nxt_pc, fetched;
      bit          redirect;
      if (rst) begin
         m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
         m_live = 1;
      end else if (m_live) begin
         seq      = m_pc + 32'd4;
         fetched  = rom[(m_pc / 4) % 256];
         redirect = m_valid && (bus1.J || bus1.JR);
         if (bus1.branch_taken)               nxt_pc = {bus1.branch_target[31:2], 2'b00};
         else if (bus1.stall)                 nxt_pc = m_pc;
         else if (m_valid && bus1.JR)         nxt_pc = {bus1.jr_target[31:2], 2'b00};
         else if (m_valid && bus1.J)          nxt_pc = {m_pc4[31:28], m_instr[25:0], 2'b00};
         else                                 nxt_pc = seq;
         if (bus1.branch_taken || bus1.flush || (!bus1.stall && redirect)) begin
            m_instr = 32'h0; m_valid = 1'b0;
         end else if (!bus1.stall) begin
            m_instr = fetched; m_pc4 = seq; m_valid = 1'b1;
         end
         m_pc = nxt_pc;
      end
      #1;
      if (m_live) begin
         chk("model_pc", bus1.PC, m_pc);
         chk("model_imem_addr", {24'h0, bus1.imem_addr}, (m_pc / 4) % 256);
         chk("model_instr", bus1.Instruction_id, m_instr);
         chk("model_pc4", bus1.PC4_id, m_pc4);
         chk("model_valid", {31'h0, bus1.valid_id}, {31'h0, m_valid});
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_ctl();
      bus1.stall = 0; bus1.flush = 0; bus1.branch_taken = 0; bus1.J = 0; bus1.JR = 0;
      bus1.branch_target = 32'h0; bus1.jr_target = 32'h0;
   endtask

   initial begin
      logic [31:0] held_instr, held_pc4;
      for (int i = 0; i < 256; i++) rom[i] = i + 1;
      rom[3] = 32'h0800_0040;
      rst = 1; stall2 = 0;
      clear_ctl();

      step();
      chk("rst_pc", bus1.PC, 32'h0);
      chk("rst_valid", {31'h0, bus1.valid_id}, 32'h0);
      chk("rst_instr", bus1.Instruction_id, 32'h0);
      chk("rst_pc4", bus1.PC4_id, 32'h0);
      chk("rst_pc_hi", bus2.PC, 32'hFFFF_FFFC);
      rst = 0;

      step();
      chk("e1_instr", bus1.Instruction_id, 32'h1);
      chk("e1_pc4", bus1.PC4_id, 32'h4);
      chk("e1_pc", bus1.PC, 32'h4);
      chk("wrap_pc", bus2.PC, 32'h0);
      chk("wrap_pc4", bus2.PC4_id, 32'h0);
      step();
      chk("e2_instr", bus1.Instruction_id, 32'h2);
      chk("e2_pc4", bus1.PC4_id, 32'h8);

      step();
      step();
      chk("j_pre_pc4", bus1.PC4_id, 32'h10);
      bus1.J = 1;
      step();
      bus1.J = 0;
      chk("j_pc", bus1.PC, 32'h100);
      chk("j_valid", {31'h0, bus1.valid_id}, 32'h0);
      step();
      chk("j_instr", bus1.Instruction_id, 32'd65);
      chk("j_valid2", {31'h0, bus1.valid_id}, 32'h1);

      bus1.JR = 1; bus1.jr_target = 32'h20;
      step();
      clear_ctl();
      chk("jr20_pc", bus1.PC, 32'h20);
      held_instr = bus1.Instruction_id;
      held_pc4   = bus1.PC4_id;
      bus1.stall = 1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall_pc", bus1.PC, 32'h20);
         chk("stall_instr", bus1.Instruction_id, held_instr);
         chk("stall_pc4", bus1.PC4_id, held_pc4);
      end
      bus1.stall = 0;
      step();
      chk("unstall_pc", bus1.PC, 32'h24);
      chk("unstall_instr", bus1.Instruction_id, 32'd9);

      bus1.branch_taken = 1; bus1.branch_target = 32'h43; bus1.stall = 1;
      step();
      clear_ctl();
      chk("br_pc", bus1.PC, 32'h40);
      chk("br_instr", bus1.Instruction_id, 32'h0);
      chk("br_valid", {31'h0, bus1.valid_id}, 32'h0);

      step();
      bus1.JR = 1; bus1.jr_target = 32'h80;
      step();
      clear_ctl();
      chk("jr80_pc", bus1.PC, 32'h80);
      chk("jr80_valid", {31'h0, bus1.valid_id}, 32'h0);
      bus1.flush = 1; bus1.stall = 1;
      step();
      clear_ctl();
      chk("fs_pc", bus1.PC, 32'h80);
      chk("fs_instr", bus1.Instruction_id, 32'h0);
      chk("fs_valid", {31'h0, bus1.valid_id}, 32'h0);

      stall2 = 1;
      step();
      rst = 1;
      step();
      rst = 0; stall2 = 0;
      chk("rststall_pc", bus2.PC, 32'hFFFF_FFFC);
      chk("rststall_valid", {31'h0, bus2.valid_id}, 32'h0);

      for (int c = 0; c < 3000; c++) begin
         rst                = ($urandom_range(63) == 0);
         bus1.stall         = ($urandom_range(5) == 0);
         bus1.flush         = ($urandom_range(11) == 0);
         bus1.branch_taken  = ($urandom_range(9) == 0);
         bus1.J             = ($urandom_range(7) == 0);
         bus1.JR            = ($urandom_range(9) == 0);
         bus1.branch_target = $urandom;
         bus1.jr_target     = $urandom;
         step();
      end
      rst = 0;
      clear_ctl();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
